// File: rtl/router_input_if.sv
// -----------------------------------------------------------------------------
// router_input_if
// Handshake/bus bundle for one router input port.
//   data_in / data_void_in / stop_out : upstream link (flit, empty marker, full)
//   request / grant / out_ready       : one-hot request to the output arbiters
//                                       and their grant plus downstream readiness
//   data_out                          : flit at the head of the input FIFO
//   forwarding_head / forwarding_tail : per-port pulses when a head/tail pops
// The slave modport is the input unit's view; master is the surrounding
// router's (or a testbench's) view.
// -----------------------------------------------------------------------------
interface router_input_if #(
   parameter int FLIT_WIDTH = 34
) ();
   logic [FLIT_WIDTH-1:0] data_in;
   logic                  data_void_in;
   logic                  stop_out;
   logic [4:0]            request;
   logic [4:0]            grant;
   logic [4:0]            out_ready;
   logic [FLIT_WIDTH-1:0] data_out;
   logic [4:0]            forwarding_head;
   logic [4:0]            forwarding_tail;

   modport master (
      output data_in, data_void_in, grant, out_ready,
      input  stop_out, request, data_out, forwarding_head, forwarding_tail
   );

   modport slave (
      input  data_in, data_void_in, grant, out_ready,
      output stop_out, request, data_out, forwarding_head, forwarding_tail
   );
endinterface

// File: rtl/router_input_unit.sv
// -----------------------------------------------------------------------------
// router_input_unit
// One NoC router input port: a DEPTH-entry flit FIFO, XY route computation on
// head flits, and a wormhole FSM that holds the route for the whole packet.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   position_x, position_y   static coordinates of this router
//   bus (router_input_if.slave)
//      data_in, data_void_in upstream flit and its "no flit" marker
//      stop_out              FIFO full, upstream holds its flit
//      request               one-hot target port (0=N,1=S,2=W,3=E,4=Local)
//      grant, out_ready      arbiter grant and downstream readiness per port
//      data_out              head-of-FIFO flit, valid while request != 0
//      forwarding_head/tail  pulse on the used port when a head/tail pops
// Optional build macro ROUTER_INPUT_UNIT_STATS_EN adds:
//   packet_count (32)        tail flits popped, wrapping
//   stall_count  (32)        cycles with request != 0 and no pop, saturating
// -----------------------------------------------------------------------------
module router_input_unit #(
   parameter int FLIT_WIDTH = 34,
   parameter int YX_WIDTH   = 3,
   parameter int DEPTH      = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [YX_WIDTH-1:0] position_x,
   input  logic [YX_WIDTH-1:0] position_y,
`ifdef ROUTER_INPUT_UNIT_STATS_EN
   output logic [31:0]         packet_count,
   output logic [31:0]         stall_count,
`endif
   router_input_if.slave       bus
);
   typedef enum logic {ST_HEAD, ST_BODY} state_t;

   localparam int PTR_W     = $clog2(DEPTH);
   localparam int DST_Y_MSB = FLIT_WIDTH - 3 - 2*YX_WIDTH;
   localparam int DST_X_MSB = DST_Y_MSB - YX_WIDTH;

   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

   localparam logic [4:0] PORT_N = 5'b00001;
   localparam logic [4:0] PORT_S = 5'b00010;
   localparam logic [4:0] PORT_W = 5'b00100;
   localparam logic [4:0] PORT_E = 5'b01000;
   localparam logic [4:0] PORT_L = 5'b10000;

   logic [FLIT_WIDTH-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        count_q, count_d;
   state_t                state_q, state_d;
   logic [4:0]            route_q, route_d;

   logic [FLIT_WIDTH-1:0] head_flit;
   logic                  head_is_head, head_is_tail;
   logic [YX_WIDTH-1:0]   dst_x, dst_y;
   logic [4:0]            route_calc;
   logic [4:0]            req;
   logic                  fifo_empty, stop, wr_en, fire;

   // Full flag comes straight from the count register so the upstream link
   // never sees a combinational path from grant/out_ready.
   assign fifo_empty = (count_q == '0);
   assign stop       = (count_q == FULL_COUNT);
   assign wr_en      = !bus.data_void_in && !stop;

   // Head flit is read straight from the array; a new write only becomes
   // visible after the count register updates, so there is no flow-through.
   assign head_flit    = fifo_mem[rd_ptr_q];
   assign head_is_head = head_flit[FLIT_WIDTH-1];
   assign head_is_tail = head_flit[FLIT_WIDTH-2];
   assign dst_y        = head_flit[DST_Y_MSB -: YX_WIDTH];
   assign dst_x        = head_flit[DST_X_MSB -: YX_WIDTH];

   // XY routing: x is resolved before y.
   always_comb begin
      route_calc = PORT_L;
      if (dst_x > position_x)      route_calc = PORT_E;
      else if (dst_x < position_x) route_calc = PORT_W;
      else if (dst_y > position_y) route_calc = PORT_S;
      else if (dst_y < position_y) route_calc = PORT_N;
   end

   // A non-head flit at the FIFO head while waiting for a head is never
   // requested, so it stalls there instead of being forwarded blindly.
   always_comb begin
      req = '0;
      if (!fifo_empty) begin
         if (state_q == ST_HEAD) begin
            if (head_is_head) req = route_calc;
         end else begin
            req = route_q;
         end
      end
   end

   assign fire = |(req & bus.grant & bus.out_ready);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      route_d  = route_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fire)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, fire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (fire) begin
         if (state_q == ST_HEAD) begin
            route_d = req;
            state_d = head_is_tail ? ST_HEAD : ST_BODY;
         end else if (head_is_tail) begin
            route_d = '0;
            state_d = ST_HEAD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_HEAD;
         route_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         route_q  <= route_d;
      end
   end

   // Storage is not reset; reset flushes the FIFO through the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= bus.data_in;
   end

   assign bus.stop_out        = stop;
   assign bus.request         = req;
   assign bus.data_out        = head_flit;
   assign bus.forwarding_head = (fire && state_q == ST_HEAD) ? req : '0;
   assign bus.forwarding_tail = (fire && head_is_tail) ? req : '0;

`ifdef ROUTER_INPUT_UNIT_STATS_EN
   logic [31:0] packet_count_q, packet_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      packet_count_d = packet_count_q;
      stall_count_d  = stall_count_q;
      if (fire && head_is_tail) packet_count_d = packet_count_q + 32'd1;
      if (req != '0 && !fire && stall_count_q != '1)
         stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         packet_count_q <= '0;
         stall_count_q  <= '0;
      end else begin
         packet_count_q <= packet_count_d;
         stall_count_q  <= stall_count_d;
      end
   end

   assign packet_count = packet_count_q;
   assign stall_count  = stall_count_q;
`endif

   a_req_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req));
   a_grant_subset: assert property (@(posedge clk) disable iff (rst)
      (req != '0) |-> ((bus.grant & ~req) == '0));
   a_no_write_full: assert property (@(posedge clk) disable iff (rst)
      !(wr_en && stop));
   a_head_expected: assert property (@(posedge clk) disable iff (rst)
      !(state_q == ST_HEAD && !fifo_empty && !head_is_head));
   a_body_expected: assert property (@(posedge clk) disable iff (rst)
      !(state_q == ST_BODY && !fifo_empty && head_is_head));
endmodule

// File: tb/tb_router_input_unit.sv
module tb_router_input_unit;
   localparam int FW    = 34;
   localparam int YX    = 3;
   localparam int DEPTH = 4;

   localparam logic [4:0] PN = 5'b00001;
   localparam logic [4:0] PS = 5'b00010;
   localparam logic [4:0] PW = 5'b00100;
   localparam logic [4:0] PE = 5'b01000;
   localparam logic [4:0] PL = 5'b10000;

   logic          clk = 1'b0;
   logic          rst;
   logic [YX-1:0] position_x, position_y;
   int            checks   = 0;
   int            failures = 0;

   router_input_if #(.FLIT_WIDTH(FW)) bus ();
`ifdef ROUTER_INPUT_UNIT_STATS_EN
   logic [31:0] packet_count, stall_count;
`endif

   router_input_unit #(.FLIT_WIDTH(FW), .YX_WIDTH(YX), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .position_x   (position_x),
      .position_y   (position_y),
`ifdef ROUTER_INPUT_UNIT_STATS_EN
      .packet_count (packet_count),
      .stall_count  (stall_count),
`endif
      .bus          (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %s observed=0x%0h ok", tag, obs);
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic h, input logic t,
                                        input logic [2:0] dy, input logic [2:0] dx,
                                        input logic [19:0] pl);
      logic [FW-1:0] f;
      f        = '0;
      f[33]    = h;
      f[32]    = t;
      f[25:23] = dy;
      f[22:20] = dx;
      f[19:0]  = pl;
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic send(input logic [FW-1:0] f);
      bus.data_in      = f;
      bus.data_void_in = 1'b0;
      step();
      bus.data_void_in = 1'b1;
      settle();
   endtask

   // One cycle with the given grant; checks outputs before the edge.
   task automatic xfer(input string tag, input logic [4:0] g, input logic [4:0] req_e,
                       input logic [4:0] fh_e, input logic [4:0] ft_e,
                       input logic [FW-1:0] d_e);
      bus.grant = g;
      settle();
      chk({tag, "_req"}, 64'(bus.request), 64'(req_e));
      chk({tag, "_fh"}, 64'(bus.forwarding_head), 64'(fh_e));
      chk({tag, "_ft"}, 64'(bus.forwarding_tail), 64'(ft_e));
      if (req_e != '0) chk({tag, "_data"}, 64'(bus.data_out), 64'(d_e));
      step();
      bus.grant = '0;
   endtask

   logic [FW-1:0] pkt [6];
   logic [FW-1:0] f_single;
   logic [2:0]    t2_dy [3];
   logic [2:0]    t2_dx [3];
   logic [4:0]    t2_port [3];
   logic [4:0]    t3_grant [5];
   logic [4:0]    t3_fh [5];
   logic [4:0]    t3_ft [5];
   int            t3_idx [5];
   int            wi;
   logic          acc;

   initial begin
      rst              = 1'b1;
      position_x       = 3'd1;
      position_y       = 3'd1;
      bus.data_in      = '0;
      bus.data_void_in = 1'b1;
      bus.grant        = '0;
      bus.out_ready    = '0;
      step();
      step();
      settle();
      chk("rst_stop", 64'(bus.stop_out), 64'(1'b0));
      chk("rst_req", 64'(bus.request), 64'(5'b0));
      chk("rst_fh", 64'(bus.forwarding_head), 64'(5'b0));
      chk("rst_ft", 64'(bus.forwarding_tail), 64'(5'b0));
`ifdef ROUTER_INPUT_UNIT_STATS_EN
      chk("rst_pkt_cnt", 64'(packet_count), 64'(0));
`endif
      rst = 1'b0;
      step();

      // Single head+tail flit to (x=3,y=1) -> East
      f_single = mk(1'b1, 1'b1, 3'd1, 3'd3, 20'h00011);
      send(f_single);
      bus.out_ready = PE;
      xfer("t1", PE, PE, PE, PE, f_single);
      settle();
      chk("t1_req_after", 64'(bus.request), 64'(5'b0));
      chk("t1_fh_after", 64'(bus.forwarding_head), 64'(5'b0));

      // XY ordering
      bus.out_ready = 5'b11111;
      t2_dy[0] = 3'd0; t2_dx[0] = 3'd1; t2_port[0] = PN;
      t2_dy[1] = 3'd2; t2_dx[1] = 3'd0; t2_port[1] = PW;
      t2_dy[2] = 3'd1; t2_dx[2] = 3'd1; t2_port[2] = PL;
      for (int i = 0; i < 3; i++) begin
         f_single = mk(1'b1, 1'b1, t2_dy[i], t2_dx[i], 20'h00020 + 20'(i));
         send(f_single);
         chk($sformatf("t2_%0d_route", i), 64'(bus.request), 64'(t2_port[i]));
         xfer($sformatf("t2_%0d", i), t2_port[i], t2_port[i], t2_port[i], t2_port[i], f_single);
      end

      // Wormhole: 4-flit packet to South, grant 1,0,1,1,1
      pkt[0] = mk(1'b1, 1'b0, 3'd2, 3'd1, 20'h00030);
      pkt[1] = mk(1'b0, 1'b0, 3'd0, 3'd0, 20'h00031);
      pkt[2] = mk(1'b0, 1'b0, 3'd0, 3'd0, 20'h00032);
      pkt[3] = mk(1'b0, 1'b1, 3'd0, 3'd0, 20'h00033);
      for (int i = 0; i < 4; i++) begin
         bus.data_in      = pkt[i];
         bus.data_void_in = 1'b0;
         step();
      end
      bus.data_void_in = 1'b1;
      settle();
      chk("t3_full", 64'(bus.stop_out), 64'(1'b1));
      t3_grant[0] = PS; t3_fh[0] = PS; t3_ft[0] = '0; t3_idx[0] = 0;
      t3_grant[1] = '0; t3_fh[1] = '0; t3_ft[1] = '0; t3_idx[1] = 1;
      t3_grant[2] = PS; t3_fh[2] = '0; t3_ft[2] = '0; t3_idx[2] = 1;
      t3_grant[3] = PS; t3_fh[3] = '0; t3_ft[3] = '0; t3_idx[3] = 2;
      t3_grant[4] = PS; t3_fh[4] = '0; t3_ft[4] = PS; t3_idx[4] = 3;
      for (int c = 0; c < 5; c++)
         xfer($sformatf("t3_c%0d", c), t3_grant[c], PS, t3_fh[c], t3_ft[c], pkt[t3_idx[c]]);
      settle();
      chk("t3_req_after", 64'(bus.request), 64'(5'b0));

      // Full / backpressure: 6-flit packet to East
      pkt[0] = mk(1'b1, 1'b0, 3'd1, 3'd3, 20'h00040);
      for (int i = 1; i < 5; i++) pkt[i] = mk(1'b0, 1'b0, 3'd0, 3'd0, 20'h00040 + 20'(i));
      pkt[5] = mk(1'b0, 1'b1, 3'd0, 3'd0, 20'h00045);
      wi = 0;
      for (int c = 0; c < 5; c++) begin
         if (wi < 6) begin
            bus.data_in      = pkt[wi];
            bus.data_void_in = 1'b0;
         end
         settle();
         acc = !bus.stop_out;
         if (c == 4) chk("t4_stop_full", 64'(bus.stop_out), 64'(1'b1));
         step();
         if (acc) wi++;
      end
      chk("t4_held", 64'(wi), 64'(4));
      bus.grant = PE;
      for (int g = 0; g < 6; g++) begin
         if (wi < 6) begin
            bus.data_in      = pkt[wi];
            bus.data_void_in = 1'b0;
         end else begin
            bus.data_void_in = 1'b1;
         end
         settle();
         chk($sformatf("t4_g%0d_stop", g), 64'(bus.stop_out), 64'(g == 0));
         chk($sformatf("t4_g%0d_req", g), 64'(bus.request), 64'(PE));
         chk($sformatf("t4_g%0d_data", g), 64'(bus.data_out), 64'(pkt[g]));
         chk($sformatf("t4_g%0d_fh", g), 64'(bus.forwarding_head), 64'((g == 0) ? PE : 5'b0));
         chk($sformatf("t4_g%0d_ft", g), 64'(bus.forwarding_tail), 64'((g == 5) ? PE : 5'b0));
         acc = !bus.stop_out;
         step();
         if (acc && wi < 6) wi++;
      end
      bus.data_void_in = 1'b1;
      bus.grant        = '0;
      settle();
      chk("t4_req_after", 64'(bus.request), 64'(5'b0));
      chk("t4_stop_after", 64'(bus.stop_out), 64'(1'b0));
      chk("t4_all_written", 64'(wi), 64'(6));

      // Simultaneous write and pop at count=2
      pkt[0] = mk(1'b1, 1'b0, 3'd0, 3'd1, 20'h00050);
      pkt[1] = mk(1'b0, 1'b0, 3'd0, 3'd0, 20'h00051);
      pkt[2] = mk(1'b0, 1'b0, 3'd0, 3'd0, 20'h00052);
      pkt[3] = mk(1'b0, 1'b1, 3'd0, 3'd0, 20'h00053);
      pkt[4] = mk(1'b1, 1'b1, 3'd1, 3'd1, 20'h00054);
      bus.data_void_in = 1'b0;
      bus.data_in      = pkt[0];
      step();
      bus.data_in      = pkt[1];
      step();
      bus.data_in      = pkt[2];
      xfer("t5_simul", PN, PN, PN, 5'b0, pkt[0]);
      bus.data_in      = pkt[3];
      step();
      bus.data_in      = pkt[4];
      settle();
      chk("t5_stop_cnt3", 64'(bus.stop_out), 64'(1'b0));
      step();
      bus.data_void_in = 1'b1;
      settle();
      chk("t5_stop_cnt4", 64'(bus.stop_out), 64'(1'b1));
      bus.out_ready = 5'b0;
      bus.grant     = PN;
      settle();
      chk("t5_nordy_req", 64'(bus.request), 64'(PN));
      chk("t5_nordy_fh", 64'(bus.forwarding_head), 64'(5'b0));
      chk("t5_nordy_ft", 64'(bus.forwarding_tail), 64'(5'b0));
      step();
      settle();
      chk("t5_nordy_data", 64'(bus.data_out), 64'(pkt[1]));
      bus.out_ready = 5'b11111;
      xfer("t5_p1", PN, PN, 5'b0, 5'b0, pkt[1]);
      xfer("t5_p2", PN, PN, 5'b0, 5'b0, pkt[2]);
      xfer("t5_p3", PN, PN, 5'b0, PN, pkt[3]);
      xfer("t5_p4", PL, PL, PL, PL, pkt[4]);
      settle();
      chk("t5_req_after", 64'(bus.request), 64'(5'b0));
`ifdef ROUTER_INPUT_UNIT_STATS_EN
      chk("t5_pkt_cnt", 64'(packet_count), 64'(8));
`endif

      // Reset in the middle of a packet
      pkt[0] = mk(1'b1, 1'b0, 3'd1, 3'd3, 20'h00060);
      for (int i = 1; i < 4; i++) pkt[i] = mk(1'b0, 1'b0, 3'd0, 3'd0, 20'h00060 + 20'(i));
      bus.data_void_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.data_in = pkt[i];
         step();
      end
      bus.data_void_in = 1'b1;
      xfer("t6_h", PE, PE, PE, 5'b0, pkt[0]);
      xfer("t6_b1", PE, PE, 5'b0, 5'b0, pkt[1]);
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      chk("t6_rst_req", 64'(bus.request), 64'(5'b0));
      chk("t6_rst_stop", 64'(bus.stop_out), 64'(1'b0));
`ifdef ROUTER_INPUT_UNIT_STATS_EN
      chk("t6_rst_pkt_cnt", 64'(packet_count), 64'(0));
      chk("t6_rst_stall_cnt", 64'(stall_count), 64'(0));
`endif
      f_single = mk(1'b1, 1'b1, 3'd1, 3'd0, 20'h00064);
      send(f_single);
      chk("t6_new_route", 64'(bus.request), 64'(PW));
      xfer("t6_new", PW, PW, PW, PW, f_single);
      f_single = mk(1'b1, 1'b1, 3'd2, 3'd1, 20'h00065);
      send(f_single);
      xfer("t6_s", PS, PS, PS, PS, f_single);
      f_single = mk(1'b1, 1'b1, 3'd1, 3'd1, 20'h00066);
      send(f_single);
      step();
      xfer("t6_l", PL, PL, PL, PL, f_single);
      settle();
`ifdef ROUTER_INPUT_UNIT_STATS_EN
      chk("t6_pkt_cnt", 64'(packet_count), 64'(3));
      chk("t6_stall_cnt", 64'(stall_count), 64'(1));
`endif
      chk("t6_req_after", 64'(bus.request), 64'(5'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
